// File: rtl/perceptron_eval_engine.sv
// Streaming perceptron classifier: loads trained weights, then evaluates a test
// set through a pipeline, tallying samples and misclassifications per run.
module perceptron_eval_engine #(
    parameter int XW        = 7,
    parameter int WW        = 14,
    parameter int FRAC      = 4,
    parameter int N_SAMPLES = 200,
    parameter int CW        = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          w_load,
    input  logic [WW-1:0] W1in,
    input  logic [WW-1:0] W2in,
    input  logic [WW-1:0] bin,
    input  logic          start,
    input  logic [XW-1:0] x1,
    input  logic [XW-1:0] x2,
    input  logic [1:0]    t,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          y_valid,
    output logic [1:0]    y,
    output logic          y_match,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sample_count,
    output logic [CW-1:0] err_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic signed [WW-1:0] w1_q, w2_q, b_q;
    logic [CW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        err_q, err_d;

    logic [XW-1:0]        s1_x1_q, s1_x2_q;
    logic [1:0]           s1_t_q;
    logic                 s1_v_q;
    logic [WW-1:0]        s2_yin_q;
    logic [1:0]           s2_t_q;
    logic                 s2_v_q;
    logic [1:0]           y_q;
    logic                 ym_q, yv_q;

    logic                 run, ctl_ok, accept, last;
    logic signed [WW-1:0] sx1, sx2;
    logic signed [2*WW-1:0] p1, p2;
    logic [WW-1:0]        yin;
    logic [1:0]           y_d;
    logic                 match_d;
    logic                 unused_prod;

    assign run      = (state_q == S_RUN);
    assign ctl_ok   = !run;
    assign in_ready = run && (acc_q < CW'(N_SAMPLES));
    assign accept   = in_valid && in_ready;
    assign last     = s2_v_q && (cnt_q == CW'(N_SAMPLES - 1));

    // Fixed-point: each product is rescaled by dropping FRAC bits, sum wraps.
    assign sx1 = {{(WW-XW){s1_x1_q[XW-1]}}, s1_x1_q};
    assign sx2 = {{(WW-XW){s1_x2_q[XW-1]}}, s1_x2_q};
    assign p1  = (2*WW)'(sx1) * (2*WW)'(w1_q);
    assign p2  = (2*WW)'(sx2) * (2*WW)'(w2_q);
    assign yin = p1[FRAC+WW-1:FRAC] + p2[FRAC+WW-1:FRAC] + b_q;

    assign unused_prod = ^{p1[2*WW-1:FRAC+WW], p1[FRAC-1:0],
                           p2[2*WW-1:FRAC+WW], p2[FRAC-1:0]};

    assign y_d     = s2_yin_q[WW-1] ? 2'b11 : 2'b01;
    assign match_d = (y_d == s2_t_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN:          if (last)  state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (start && ctl_ok) begin
            acc_d = '0;
            cnt_d = '0;
            err_d = '0;
        end else begin
            if (accept) acc_d = acc_q + 1'b1;
            if (s2_v_q) begin
                cnt_d = cnt_q + 1'b1;
                if (!match_d && err_q != '1) err_d = err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            w1_q     <= '0;
            w2_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            s1_x1_q  <= '0;
            s1_x2_q  <= '0;
            s1_t_q   <= '0;
            s1_v_q   <= 1'b0;
            s2_yin_q <= '0;
            s2_t_q   <= '0;
            s2_v_q   <= 1'b0;
            y_q      <= '0;
            ym_q     <= 1'b0;
            yv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (w_load && ctl_ok) begin
                w1_q <= W1in;
                w2_q <= W2in;
                b_q  <= bin;
            end
            s1_v_q <= accept;
            if (accept) begin
                s1_x1_q <= x1;
                s1_x2_q <= x2;
                s1_t_q  <= t;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_yin_q <= yin;
                s2_t_q   <= s1_t_q;
            end
            yv_q <= s2_v_q;
            if (s2_v_q) begin
                y_q  <= y_d;
                ym_q <= match_d;
            end
        end
    end

    assign y_valid      = yv_q;
    assign y            = y_q;
    assign y_match      = ym_q;
    assign busy         = run;
    assign done         = (state_q == S_DONE);
    assign sample_count = cnt_q;
    assign err_count    = err_q;

endmodule
